// File: rtl/arm_mmio_pkg.sv
// Shared constants for the ARM data-memory / MMIO stage.
// Register offsets, CTRL bit positions and reset values.
package arm_mmio_pkg;

    localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_CMP      = 8'h0C;
    localparam logic [7:0] OFF_CTRL     = 8'h10;
    localparam logic [7:0] OFF_STATUS   = 8'h14;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQEN  = 2;

    localparam logic [31:0] CMP_RST = 32'hFFFFFFFF;

endpackage

// File: rtl/arm_dmem_mmio_sync2.sv
// Parameterised-width two-flop synchroniser.
// Synchronous active-high reset clears both stages.
module sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/arm_dmem_mmio.sv
// Data-side memory stage: word RAM plus an MMIO page with
// GPIO and a compare timer with a sticky match interrupt.
module arm_dmem_mmio
    import arm_mmio_pkg::*;
#(
    parameter int          DEPTH  = 64,
    parameter logic [15:0] IO_TAG = 16'hFFFF,
    parameter int          GPIO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [AW-1:0]     idx;
    logic              io_sel;
    logic              io_map;
    logic [7:0]        off;
    logic [GPIO_W-1:0] gpio_sync;
    logic              unused_addr;

    logic [GPIO_W-1:0] gpio_q;
    logic [31:0]       count_q, count_d;
    logic [31:0]       cmp_q;
    logic [2:0]        ctrl_q;
    logic              match_q, match_d;

    logic we_gpio, we_count, we_cmp, we_ctrl, we_status;
    logic hit;
    logic [31:0] io_rdata;

    assign idx         = Addr[AW+1:2];
    assign io_sel      = (Addr[31:16] == IO_TAG);
    assign io_map      = io_sel && (Addr[15:8] == 8'h00);
    assign off         = {Addr[7:2], 2'b00};
    assign unused_addr = ^Addr[1:0];

    assign we_gpio   = MemWrite && io_map && (off == OFF_GPIO_OUT);
    assign we_count  = MemWrite && io_map && (off == OFF_COUNT);
    assign we_cmp    = MemWrite && io_map && (off == OFF_CMP);
    assign we_ctrl   = MemWrite && io_map && (off == OFF_CTRL);
    assign we_status = MemWrite && io_map && (off == OFF_STATUS);

    sync2 #(.W(GPIO_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (gpio_in),
        .q_o   (gpio_sync)
    );

    // RAM has no reset; a store completes even while reset is high.
    always_ff @(posedge clk) begin
        if (MemWrite && !io_sel)
            mem[idx] <= WriteData;
    end

    // Hit is judged on the pre-write COUNT even when the CPU overwrites it.
    assign hit = ctrl_q[CTRL_EN] && (count_q == cmp_q);

    always_comb begin
        count_d = count_q;
        if (we_count)
            count_d = WriteData;
        else if (ctrl_q[CTRL_EN]) begin
            if (hit && ctrl_q[CTRL_RELOAD])
                count_d = 32'd0;
            else
                count_d = count_q + 32'd1;
        end
    end

    always_comb begin
        match_d = match_q;
        if (hit)
            match_d = 1'b1;
        else if (we_status && WriteData[0])
            match_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q  <= '0;
            count_q <= 32'd0;
            cmp_q   <= CMP_RST;
            ctrl_q  <= 3'b000;
            match_q <= 1'b0;
        end else begin
            if (we_gpio)
                gpio_q <= WriteData[GPIO_W-1:0];
            if (we_cmp)
                cmp_q <= WriteData;
            if (we_ctrl)
                ctrl_q <= WriteData[2:0];
            count_q <= count_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        io_rdata = 32'd0;
        if (io_map) begin
            unique case (off)
                OFF_GPIO_OUT: io_rdata = 32'(gpio_q);
                OFF_GPIO_IN:  io_rdata = 32'(gpio_sync);
                OFF_COUNT:    io_rdata = count_q;
                OFF_CMP:      io_rdata = cmp_q;
                OFF_CTRL:     io_rdata = {29'd0, ctrl_q};
                OFF_STATUS:   io_rdata = {31'd0, match_q};
                default:      io_rdata = 32'd0;
            endcase
        end
    end

    assign ReadData  = io_sel ? io_rdata : mem[idx];
    assign gpio_out  = gpio_q;
    assign timer_irq = match_q && ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_arm_dmem_mmio.sv
// Directed bench for arm_dmem_mmio: RAM, GPIO, timer,
// event priority and reset behaviour.
module tb_arm_dmem_mmio;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] A_GPO = 32'hFFFF0000;
    localparam logic [31:0] A_GPI = 32'hFFFF0004;
    localparam logic [31:0] A_CNT = 32'hFFFF0008;
    localparam logic [31:0] A_CMP = 32'hFFFF000C;
    localparam logic [31:0] A_CTL = 32'hFFFF0010;
    localparam logic [31:0] A_STS = 32'hFFFF0014;

    arm_dmem_mmio #(
        .DEPTH  (64),
        .IO_TAG (16'hFFFF),
        .GPIO_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        Addr      = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rchk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
        MemWrite = 1'b0;
        Addr     = a;
        #1;
        chk(tag, ReadData, exp);
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        Addr      = 32'd0;
        WriteData = 32'd0;
        gpio_in   = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_gpio_out", 32'(gpio_out), 32'd0);
        chk("rst_irq", 32'(timer_irq), 32'd0);
        rchk("rst_count", A_CNT, 32'd0);
        rchk("rst_cmp", A_CMP, 32'hFFFFFFFF);
        rchk("rst_ctrl", A_CTL, 32'd0);
        rchk("rst_status", A_STS, 32'd0);

        // RAM store/load, read-during-write and aliasing
        wr(32'h20, 32'h11111111);
        MemWrite  = 1'b1;
        Addr      = 32'h20;
        WriteData = 32'hDEADBEEF;
        #1;
        chk("ram_raw_old", ReadData, 32'h11111111);
        tick();
        MemWrite = 1'b0;
        rchk("ram_load", 32'h20, 32'hDEADBEEF);
        rchk("ram_alias", 32'h120, 32'hDEADBEEF);
        rchk("ram_byteoff", 32'h23, 32'hDEADBEEF);

        // GPIO
        wr(A_GPO, 32'h1A5);
        chk("gpio_out", 32'(gpio_out), 32'h000000A5);
        rchk("gpio_out_rd", A_GPO, 32'h000000A5);
        gpio_in = 8'h3C;
        tick();
        rchk("gpio_in_1edge", A_GPI, 32'd0);
        tick();
        rchk("gpio_in_2edge", A_GPI, 32'h3C);

        // Timer one-shot with interrupt
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'd0);
        wr(A_CTL, 32'b101);
        repeat (5) tick();
        rchk("os_cnt5", A_CNT, 32'd5);
        chk("os_irq_pre", 32'(timer_irq), 32'd0);
        tick();
        rchk("os_match", A_STS, 32'd1);
        chk("os_irq", 32'(timer_irq), 32'd1);
        rchk("os_cnt6", A_CNT, 32'd6);
        tick();
        rchk("os_cnt7", A_CNT, 32'd7);
        wr(A_STS, 32'd1);
        chk("os_irq_clr", 32'(timer_irq), 32'd0);
        rchk("os_sts_clr", A_STS, 32'd0);
        rchk("os_cnt8", A_CNT, 32'd8);
        wr(A_CTL, 32'd0);

        // Auto-reload sequence 0,1,2,3,0,1
        wr(A_CMP, 32'd3);
        wr(A_CNT, 32'd0);
        wr(A_CTL, 32'b011);
        rchk("ar_0", A_CNT, 32'd0);
        tick();
        rchk("ar_1", A_CNT, 32'd1);
        tick();
        rchk("ar_2", A_CNT, 32'd2);
        tick();
        rchk("ar_3", A_CNT, 32'd3);
        tick();
        rchk("ar_0b", A_CNT, 32'd0);
        rchk("ar_match", A_STS, 32'd1);
        chk("ar_irq_masked", 32'(timer_irq), 32'd0);
        tick();
        rchk("ar_1b", A_CNT, 32'd1);
        wr(A_STS, 32'd0);
        rchk("sts_w0_noeff", A_STS, 32'd1);
        wr(A_CTL, 32'd0);
        wr(A_STS, 32'd1);
        rchk("sts_w1c", A_STS, 32'd0);
        rchk("ctrl_rd", A_CTL, 32'd0);

        // Wrap 0xFFFFFFFF -> 0 without a match
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'hFFFFFFFF);
        wr(A_CTL, 32'b001);
        rchk("wr_pre", A_CNT, 32'hFFFFFFFF);
        tick();
        rchk("wrap_cnt", A_CNT, 32'd0);
        rchk("wrap_nomatch", A_STS, 32'd0);
        wr(A_CTL, 32'd0);

        // Hit coinciding with STATUS W1C: set wins
        wr(A_CMP, 32'd10);
        wr(A_CNT, 32'd8);
        wr(A_CTL, 32'b001);
        tick();
        tick();
        rchk("pr_cnt10", A_CNT, 32'd10);
        rchk("pr_sts0", A_STS, 32'd0);
        wr(A_STS, 32'd1);
        rchk("pr_w1c_set", A_STS, 32'd1);
        rchk("pr_cnt11", A_CNT, 32'd11);

        // Hit coinciding with a COUNT write: write wins, match set
        wr(A_STS, 32'd1);
        rchk("pr_sts_clr", A_STS, 32'd0);
        wr(A_CMP, 32'd13);
        rchk("pr_cnt13", A_CNT, 32'd13);
        wr(A_CNT, 32'd100);
        rchk("pr_cnt100", A_CNT, 32'd100);
        rchk("pr_cw_match", A_STS, 32'd1);

        // Reset during MemWrite to CTRL, timer running
        wr(A_CTL, 32'b101);
        chk("pre_rst_irq", 32'(timer_irq), 32'd1);
        reset     = 1'b1;
        MemWrite  = 1'b1;
        Addr      = A_CTL;
        WriteData = 32'd7;
        tick();
        reset    = 1'b0;
        MemWrite = 1'b0;
        chk("mr_gpio_out", 32'(gpio_out), 32'd0);
        chk("mr_irq", 32'(timer_irq), 32'd0);
        rchk("mr_ctrl", A_CTL, 32'd0);
        rchk("mr_count", A_CNT, 32'd0);
        rchk("mr_cmp", A_CMP, 32'hFFFFFFFF);
        rchk("mr_status", A_STS, 32'd0);
        rchk("mr_gpio_in", A_GPI, 32'd0);
        rchk("mr_ram_keep", 32'h20, 32'hDEADBEEF);
        rchk("unmapped_100", 32'hFFFF0100, 32'd0);
        rchk("unmapped_18", 32'hFFFF0018, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
